// File: rtl/pipelined_ram_if.sv
// Request/response bus of the pipelined word RAM. The master issues requests
// and consumes read responses; the slave is the RAM.
interface pipelined_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic                  ReqValid;
  logic                  ReqReady;
  logic                  ReqWrite;
  logic [ADDR_WIDTH-1:0] ReqAddr;
  logic [BYTES-1:0]      ReqByteEn;
  logic [DATA_WIDTH-1:0] ReqWData;
  logic                  RspValid;
  logic                  RspReady;
  logic [DATA_WIDTH-1:0] RspData;

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqByteEn, ReqWData, RspReady,
    input  ReqReady, RspValid, RspData
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqByteEn, ReqWData, RspReady,
    output ReqReady, RspValid, RspData
  );
endinterface

// File: rtl/pipelined_ram.sv
// Word RAM with byte-lane writes, a fixed-depth read pipeline and a credit-
// limited response FIFO, so read data is never dropped under backpressure.
module pipelined_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 2
) (
  input  logic            Clock,
  input  logic            Reset,
  pipelined_ram_if.slave  bus
);
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int RSP_DEPTH = READ_LATENCY + 2;
  localparam int PTR_W     = $clog2(RSP_DEPTH);
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

  if ((DATA_WIDTH % 8) != 0 || READ_LATENCY < 1 || READ_LATENCY > 4) begin : gBadParams
    $error("pipelined_ram: DATA_WIDTH must be a multiple of 8 and READ_LATENCY in 1..4");
  end

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] fifoMem [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] pipeData [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipeValid;

  logic             reqAccept;
  logic             readAccept;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] fifoCount;
  logic [CNT_W-1:0] outstanding;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits cover both pipeline and FIFO, so every accepted read has a slot.
  assign bus.ReqReady = !Reset && (outstanding < CNT_W'(RSP_DEPTH));
  assign reqAccept    = bus.ReqValid && bus.ReqReady;
  assign readAccept   = reqAccept && !bus.ReqWrite;
  assign push         = pipeValid[READ_LATENCY-1];
  assign bus.RspValid = (fifoCount != '0);
  assign bus.RspData  = fifoMem[rdPtr];
  assign pop          = bus.RspValid && bus.RspReady;

  // NOTE: storage arrays carry no reset; only valid bits, pointers and counters do.
  always_ff @(posedge Clock) begin
    if (reqAccept && bus.ReqWrite) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.ReqByteEn[b]) mem[bus.ReqAddr][8*b +: 8] <= bus.ReqWData[8*b +: 8];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (readAccept) pipeData[0] <= mem[bus.ReqAddr];
    for (int s = 1; s < READ_LATENCY; s++) pipeData[s] <= pipeData[s-1];
    if (push) fifoMem[wrPtr] <= pipeData[READ_LATENCY-1];
  end

  // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pipeValid   <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifoCount   <= '0;
      outstanding <= '0;
    end else begin
      pipeValid[0] <= readAccept;
      for (int s = 1; s < READ_LATENCY; s++) pipeValid[s] <= pipeValid[s-1];
      if (push) wrPtr <= nextPtr(wrPtr);
      if (pop)  rdPtr <= nextPtr(rdPtr);
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + CNT_W'(1);
        2'b01:   fifoCount <= fifoCount - CNT_W'(1);
        default: fifoCount <= fifoCount;
      endcase
      case ({readAccept, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule

// File: tb/tb_pipelined_ram.sv
// Bench for pipelined_ram: default instance checked through a reference model
// and response scoreboard, plus latency-1 and latency-4/64-bit instances.
module tb_pipelined_ram;
  localparam int AW = 14;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  pipelined_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) bus ();
  pipelined_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus)
  );

  logic        swValid, swWrite, swRspReady;
  logic [5:0]  swAddr;
  logic [7:0]  swByteEn;
  logic [63:0] swWData;

  pipelined_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) busL1 ();
  pipelined_ram_if #(.DATA_WIDTH(64), .ADDR_WIDTH(6)) busL4 ();
  pipelined_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LATENCY(1)) dutL1 (
    .Clock(Clock), .Reset(Reset), .bus(busL1)
  );
  pipelined_ram #(.DATA_WIDTH(64), .ADDR_WIDTH(6), .READ_LATENCY(4)) dutL4 (
    .Clock(Clock), .Reset(Reset), .bus(busL4)
  );

  assign busL1.ReqValid  = swValid;
  assign busL1.ReqWrite  = swWrite;
  assign busL1.ReqAddr   = swAddr;
  assign busL1.ReqByteEn = swByteEn[3:0];
  assign busL1.ReqWData  = swWData[31:0];
  assign busL1.RspReady  = swRspReady;
  assign busL4.ReqValid  = swValid;
  assign busL4.ReqWrite  = swWrite;
  assign busL4.ReqAddr   = swAddr;
  assign busL4.ReqByteEn = swByteEn;
  assign busL4.ReqWData  = swWData;
  assign busL4.RspReady  = swRspReady;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [int];
  logic [31:0] sbQ [$];
  int          popCyc [$];
  int          popCount = 0;
  logic [31:0] monExp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every popped response must match the oldest expected read.
  always @(negedge Clock) begin
    if (Reset !== 1'b1 && bus.RspValid === 1'b1 && bus.RspReady === 1'b1) begin
      if (sbQ.size() == 0) begin
        check("rsp_unexpected", {63'd0, bus.RspValid}, 64'd0);
      end else begin
        monExp = sbQ.pop_front();
        check("rsp_data", {32'd0, bus.RspData}, {32'd0, monExp});
      end
      popCyc.push_back(cyc);
      popCount++;
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input int maxWait,
                       output bit accepted, output int waits);
    logic rdy;
    logic [31:0] w;
    bus.ReqValid  = 1'b1;
    bus.ReqWrite  = wr;
    bus.ReqAddr   = addr;
    bus.ReqWData  = data;
    bus.ReqByteEn = be;
    accepted = 1'b0;
    waits    = 0;
    for (int i = 0; i < maxWait && !accepted; i++) begin
      @(negedge Clock);
      rdy = bus.ReqReady;
      @(posedge Clock);
      #1;
      if (rdy === 1'b1) accepted = 1'b1;
      else waits++;
    end
    bus.ReqValid = 1'b0;
    if (accepted) begin
      if (wr) begin
        w = model.exists(int'(addr)) ? model[int'(addr)] : 32'hxxxx_xxxx;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = data[8*b +: 8];
        model[int'(addr)] = w;
      end else begin
        sbQ.push_back(model[int'(addr)]);
      end
    end
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] be);
    bit acc;
    int w;
    issue(1'b1, addr, data, be, 20, acc, w);
    check("write_accept", {63'd0, acc}, 64'd1);
  endtask

  task automatic rd(input logic [AW-1:0] addr, output int waits);
    bit acc;
    issue(1'b0, addr, 32'd0, 4'h0, 20, acc, waits);
    check("read_accept", {63'd0, acc}, 64'd1);
  endtask

  initial begin
    int  w;
    int  stalls;
    int  seen;
    int  pop0;
    bit  acc;
    int  latL1, latL4, accL1, accL4, popL1, popL4;

    bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqAddr = '0;
    bus.ReqByteEn = '0; bus.ReqWData = '0; bus.RspReady = 1'b1;
    swValid = 1'b0; swWrite = 1'b0; swAddr = '0; swByteEn = '0; swWData = '0;
    swRspReady = 1'b1;

    // Reset state
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("reset_ready_low", {63'd0, bus.ReqReady}, 64'd0);
    check("reset_rspvalid_low", {63'd0, bus.RspValid}, 64'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    check("ready_after_reset", {63'd0, bus.ReqReady}, 64'd1);
    @(posedge Clock); #1;

    // Write then read-back, latency 2 and one-cycle-wide response
    wr(14'd5, 32'hDEAD_BEEF, 4'hF);
    rd(14'd5, w);
    @(negedge Clock); check("lat_edge0", {63'd0, bus.RspValid}, 64'd0);
    @(negedge Clock); check("lat_edge1", {63'd0, bus.RspValid}, 64'd0);
    @(negedge Clock); check("lat_edge2", {63'd0, bus.RspValid}, 64'd1);
    check("lat_data", {32'd0, bus.RspData}, 64'hDEAD_BEEF);
    @(negedge Clock); check("rsp_one_wide", {63'd0, bus.RspValid}, 64'd0);
    @(posedge Clock); #1;

    // Byte lanes
    wr(14'd9, 32'h1122_3344, 4'hF);
    wr(14'd9, 32'hAABB_CCDD, 4'b0101);
    rd(14'd9, w);
    repeat (5) @(posedge Clock);
    #1;
    check("bytelane_drained", 64'(sbQ.size()), 64'd0);

    // Streaming
    for (int a = 0; a < 16; a++) wr(AW'(a), 32'(a * 3), 4'hF);
    popCyc.delete();
    stalls = 0;
    for (int a = 0; a < 16; a++) begin
      rd(AW'(a), w);
      stalls += w;
    end
    repeat (6) @(posedge Clock);
    #1;
    check("stream_no_stall", 64'(stalls), 64'd0);
    check("stream_count", 64'(popCyc.size()), 64'd16);
    if (popCyc.size() == 16) check("stream_back_to_back", 64'(popCyc[15] - popCyc[0]), 64'd15);

    // Backpressure: four credits, head held stable
    bus.RspReady = 1'b0;
    stalls = 0;
    for (int a = 0; a < 4; a++) begin
      rd(AW'(a), w);
      stalls += w;
    end
    check("bp_first4_no_stall", 64'(stalls), 64'd0);
    issue(1'b0, 14'd4, 32'd0, 4'h0, 5, acc, w);
    check("bp_fifth_blocked", {63'd0, acc}, 64'd0);
    @(negedge Clock);
    check("bp_ready_low", {63'd0, bus.ReqReady}, 64'd0);
    check("bp_head", {32'd0, bus.RspData}, {32'd0, model[0]});
    repeat (2) @(negedge Clock);
    check("bp_head_stable", {31'd0, bus.RspValid, bus.RspData}, {31'd0, 1'b1, model[0]});
    @(posedge Clock); #1;
    pop0 = popCount;
    bus.RspReady = 1'b1;
    for (int a = 4; a < 10; a++) rd(AW'(a), w);
    repeat (10) @(posedge Clock);
    #1;
    check("bp_all_returned", 64'(popCount - pop0), 64'd10);
    check("bp_sb_empty", 64'(sbQ.size()), 64'd0);

    // Reset with reads in flight
    wr(14'd100, 32'hCAFE_F00D, 4'hF);
    rd(14'd1, w);
    rd(14'd2, w);
    rd(14'd3, w);
    Reset = 1'b1;
    @(negedge Clock);
    check("rst_ready_low", {63'd0, bus.ReqReady}, 64'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    sbQ.delete();
    @(negedge Clock);
    check("rst_ready_after", {63'd0, bus.ReqReady}, 64'd1);
    seen = 0;
    repeat (6) begin
      @(negedge Clock);
      if (bus.RspValid === 1'b1) seen++;
    end
    check("rst_no_stale_rsp", 64'(seen), 64'd0);
    @(posedge Clock); #1;
    pop0 = popCount;
    rd(14'd100, w);
    repeat (5) @(posedge Clock);
    #1;
    check("rst_mem_kept_pop", 64'(popCount - pop0), 64'd1);

    // Latency sweep on the latency-1 and latency-4/64-bit instances
    @(posedge Clock); #1;
    swValid = 1'b1; swWrite = 1'b1; swAddr = 6'd5;
    swWData = 64'h0123_4567_89AB_CDEF; swByteEn = 8'hFF;
    @(negedge Clock);
    check("sw_l1_ready", {63'd0, busL1.ReqReady}, 64'd1);
    check("sw_l4_ready", {63'd0, busL4.ReqReady}, 64'd1);
    @(posedge Clock); #1;
    swWrite = 1'b0;
    @(posedge Clock); #1;
    swValid = 1'b0;
    latL1 = -1;
    latL4 = -1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clock);
      if (latL1 < 0 && busL1.RspValid === 1'b1) begin
        latL1 = k - 1;
        check("sw_l1_data", {32'd0, busL1.RspData}, 64'h89AB_CDEF);
      end
      if (latL4 < 0 && busL4.RspValid === 1'b1) begin
        latL4 = k - 1;
        check("sw_l4_data", busL4.RspData, 64'h0123_4567_89AB_CDEF);
      end
    end
    check("sw_l1_latency", 64'(latL1), 64'd1);
    check("sw_l4_latency", 64'(latL4), 64'd4);

    @(posedge Clock); #1;
    swRspReady = 1'b0;
    swValid = 1'b1;
    accL1 = 0;
    accL4 = 0;
    repeat (10) begin
      @(negedge Clock);
      if (busL1.ReqReady === 1'b1) accL1++;
      if (busL4.ReqReady === 1'b1) accL4++;
      @(posedge Clock); #1;
    end
    swValid = 1'b0;
    check("sw_l1_credits", 64'(accL1), 64'd3);
    check("sw_l4_credits", 64'(accL4), 64'd6);
    @(negedge Clock);
    check("sw_l4_head", busL4.RspData, 64'h0123_4567_89AB_CDEF);
    @(posedge Clock); #1;
    swRspReady = 1'b1;
    popL1 = 0;
    popL4 = 0;
    repeat (12) begin
      @(negedge Clock);
      if (busL1.RspValid === 1'b1) popL1++;
      if (busL4.RspValid === 1'b1) popL4++;
    end
    check("sw_l1_drain", 64'(popL1), 64'd3);
    check("sw_l4_drain", 64'(popL4), 64'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_ram.md
Name: pipelined_ram

Overview:
- Parametrised successor to the single-cycle word RAM used on the processor memory bus. Adds configurable data/address width, byte-lane write enables, configurable read latency, and a valid/ready request/response handshake with response backpressure.
- Sits between a processor or bus master and word-addressed storage. Serves as a drop-in memory model for processor benches and as a synthesizable on-chip RAM.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 14, word-address width; depth = 2**ADDR_WIDTH words.
- READ_LATENCY, 2, cycles from read accept to earliest RspValid; legal range 1..4.
- BYTES (derived), DATA_WIDTH/8, number of byte lanes.
- RSP_DEPTH (derived), READ_LATENCY+2, response buffer / credit limit.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous reset, active-high
- ReqValid  in  1  request present
- ReqReady  out  1  block can accept a request this cycle
- ReqWrite  in  1  1 = write, 0 = read
- ReqAddr  in  ADDR_WIDTH  word address
- ReqByteEn  in  BYTES  per-lane write enable; ignored for reads
- ReqWData  in  DATA_WIDTH  write data
- RspValid  out  1  read data available
- RspReady  in  1  consumer accepts response
- RspData  out  DATA_WIDTH  read data, returned in request order

Behaviour:
- Accept: a request is accepted on any rising edge where ReqValid && ReqReady. At most one request (read or write) is accepted per cycle.
- Write: on the accept edge, lane b of mem[ReqAddr] takes ReqWData[8b+7:8b] iff ReqByteEn[b]; other lanes are unchanged. ByteEn = 0 is accepted as a no-op. Writes produce no response.
- Read:
  - mem[ReqAddr] is sampled on the accept edge, so a read accepted the cycle after a write to the same address returns the new data.
  - The sampled word passes through READ_LATENCY register stages, then enters a FIFO of RSP_DEPTH entries.
  - RspValid is asserted exactly READ_LATENCY cycles after accept if the FIFO was empty, otherwise later.
- Response:
  - RspValid = FIFO non-empty; RspData = FIFO head.
  - A pop occurs when RspValid && RspReady.
  - While RspValid && !RspReady, RspData is held stable.
  - Responses come out strictly in request order.
- Credits:
  - outstanding = reads in the latency pipeline + FIFO occupancy.
  - Increments on read accept, decrements on pop; a simultaneous accept and pop leaves it unchanged.
  - ReqReady = (outstanding < RSP_DEPTH). It is a function of registered state only, with no combinational path from ReqValid or RspReady. Writes are also blocked while ReqReady = 0.
  - The FIFO can never overflow.
- Throughput: with RspReady held at 1, one read per cycle is sustained indefinitely (ReqReady stays 1).
- Reset (synchronous, active-high):
  - Clears pipeline valid bits, FIFO pointers and the outstanding counter.
  - Outputs: RspValid = 0; ReqReady = 0 while Reset = 1, and 1 on the first cycle after Reset deasserts. RspData is don't-care while RspValid = 0.
  - Memory contents are not cleared.
  - Reset mid-operation: in-flight and buffered reads are discarded and never appear on the response port. Writes accepted before the reset edge persist.
  - Requests presented while Reset = 1 are not accepted.
- Address: no range check; every ADDR_WIDTH value is valid.
- Uninitialised words read as X in simulation.

Test Plan:
- Defaults. Write addr 5, data 0xDEADBEEF, ByteEn 4'hF. Next cycle read addr 5 with RspReady = 1 → RspValid rises exactly 2 cycles after the read accept, RspData = 0xDEADBEEF, 1 cycle wide.
- Byte lanes. Write 0x11223344 to addr 9 with ByteEn 4'hF, then 0xAABBCCDD with ByteEn 4'b0101, then read addr 9 → RspData = 0x11BB33DD.
- Streaming. Write addrs 0..15 with value = addr*3. Issue 16 back-to-back reads with RspReady = 1 → ReqReady never drops; responses are 0,3,...,45 in order on consecutive cycles.
- Backpressure. Hold RspReady = 0 and issue reads to addrs 0..9 → exactly 4 accepted (RSP_DEPTH = 4), then ReqReady = 0 and RspData stable at the first value. Raise RspReady → all 10 values return in order, none lost or duplicated.
- Reset mid-flight. Issue 3 reads, assert Reset for 1 cycle while 2 are still in the pipeline → no RspValid afterwards, ReqReady = 1 after reset. Re-read an address written before reset → old data intact.
- Latency sweep. Repeat the first scenario with READ_LATENCY = 1 and 4, and DATA_WIDTH = 64 → read-to-RspValid distance equals READ_LATENCY; backpressure limit equals READ_LATENCY+2.
